md_issue_ctrl: RTL

E-stage issue controller for the HI/LO multiply/divide unit of the pipelined CPU. Decodes the E-stage MD instruction class, issues single-cycle `start`/`mthi`/`mtlo` pulses to the multiply/divide unit, and tracks each operation with its own latency counter plus the unit's `busy`. Raises the E-stage stall for any MD instruction that would touch the unit while it is occupied. Suppresses issue when the pipeline flushes E for an exception or interrupt.

---
 rtl/md_issue_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/md_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : md_issue_ctrl
// Brief    : E-stage issue/stall controller for the HI/LO multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
module md_issue_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_valid,
    input  logic [3:0]  e_md_op,
    input  logic [31:0] e_rs,
    input  logic [31:0] e_rt,
    input  logic        flush,
    input  logic        md_busy,
    input  logic [31:0] md_hi,
    input  logic [31:0] md_lo,
    output logic        md_start,
    output logic [1:0]  md_ctrl,
    output logic        md_mthi,
    output logic        md_mtlo,
    output logic [31:0] md_inA,
    output logic [31:0] md_inB,
    output logic [31:0] md_dataW,
    output logic [31:0] e_md_rdata,
    output logic        stall_e,
    output logic        md_pending
);

    localparam int c_max_lat = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int c_cnt_w   = $clog2(c_max_lat + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic                 w_is_md;
    logic                 w_go;
    logic [1:0]           w_op_low;

    assign md_inA     = e_rs;
    assign md_inB     = e_rt;
    assign md_dataW   = e_rs;
    assign md_pending = (r_state == ST_WAIT);
    // Low two bits of (op - 1) map mult/multu/div/divu onto 00..11.
    assign w_op_low   = e_md_op[1:0] - 2'd1;

    always_comb begin
        case (e_md_op)
            4'd5:    e_md_rdata = md_hi;
            4'd6:    e_md_rdata = md_lo;
            default: e_md_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_is_md     = e_valid && (e_md_op >= 4'd1) && (e_md_op <= 4'd8);
        // Busy in IDLE covers a unit still running across a reset.
        stall_e     = w_is_md && ((r_state == ST_WAIT) || md_busy);
        w_go        = w_is_md && !stall_e && !flush && !reset;
        md_start    = w_go && (e_md_op <= 4'd4);
        md_ctrl     = md_start ? w_op_low : 2'b00;
        md_mthi     = w_go && (e_md_op == 4'd7);
        md_mtlo     = w_go && (e_md_op == 4'd8);

        case (r_state)
            ST_IDLE: begin
                if (md_start) begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = (e_md_op <= 4'd2) ? c_cnt_w'(MULT_LAT)
                                                    : c_cnt_w'(DIV_LAT);
                end
            end
            ST_WAIT: begin
                if (r_cnt > c_cnt_w'(1)) begin
                    w_cnt_nxt = r_cnt - c_cnt_w'(1);
                end else if (!md_busy) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    // Unit slower than the nominal latency: park at 1.
                    w_cnt_nxt = c_cnt_w'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

endmodule
`default_nettype wire
